riscv_multicycle_ctrl: RTL and testbench

RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/riscv_alu_decoder.sv | 31 +++
 rtl/riscv_multicycle_ctrl.sv | 162 ++++++++++++++++
 tb/tb_riscv_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes and mux selects.
// The JAL state exists only when RISCV_CTRL_JAL_EN is defined.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_ALUWB,
        S_EXECUTEI,
`ifdef RISCV_CTRL_JAL_EN
        S_JAL,
`endif
        S_BEQ
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's alu_op plus funct3/funct7 bits to an ALU operation.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e     alu_op,
    input  logic [2:0]  funct3,
    input  logic        op_b5,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: alu_control = ALU_ADD;
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // funct7b5 only means sub for R-type; addi with imm[10]=1 stays add
                    3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RISC-V control FSM (lw, sw, R, I, beq; jal when RISCV_CTRL_JAL_EN is defined).
// Write enables and status pulses are held low while s_rst is asserted.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        s_rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_write,
    output logic        adr_src,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        instr_retired,
    output logic        illegal_instr
);

    state_e  state_q, state_d;
    alu_op_e alu_op;
    logic    pc_update, branch;
    logic    ir_write_raw, reg_write_raw, mem_write_raw;
    logic    retired_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (s_rst) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        alu_op        = ALU_OP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        retired_raw   = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                pc_update    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef RISCV_CTRL_JAL_EN
                    OP_JAL:       state_d = S_JAL;
`endif
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                retired_raw   = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef RISCV_CTRL_JAL_EN
            S_JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                pc_update   = 1'b1;
                retired_raw = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            S_BEQ: begin
                alu_src_a   = SRCA_RS1;
                alu_op      = ALU_OP_SUB;
                branch      = 1'b1;
                retired_raw = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
`ifdef RISCV_CTRL_JAL_EN
            OP_JAL:      imm_src = IMM_J;
`endif
            default:     imm_src = IMM_I;
        endcase
    end

    always_comb begin
        pc_write      = ~s_rst & (pc_update | (branch & zero));
        ir_write      = ~s_rst & ir_write_raw;
        reg_write     = ~s_rst & reg_write_raw;
        mem_write     = ~s_rst & mem_write_raw;
        instr_retired = ~s_rst & retired_raw;
        illegal_instr = ~s_rst & illegal_raw;
    end

    riscv_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op_b5       (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: instruction table with expected state sequences, checked per cycle
// through a scoreboard queue. Expectations follow RISCV_CTRL_JAL_EN when it is defined.
module tb_riscv_multicycle_ctrl;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXECR = 6, ST_ALUWB = 7, ST_EXECI = 8, ST_JAL = 9, ST_BEQ = 10;

    logic        clk = 1'b0;
    logic        s_rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]  alu_control;
    logic        instr_retired, illegal_instr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         len;
        int         st [5];
    } vec_t;

    vec_t        tbl [$];
    logic [17:0] sb  [$];

    riscv_multicycle_ctrl dut (
        .clk           (clk),
        .s_rst         (s_rst),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // Expected output word: {pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
    // alu_src_a, alu_src_b, imm_src, alu_control, instr_retired, illegal_instr}
    function automatic logic [17:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z, input logic rst);
        logic pcu, br, irw, rw, mw, adr, ret, ill, pcw, supported;
        logic [1:0] rs, sa, sbs, imm, aop;
        logic [2:0] ac;
        {pcu, br, irw, rw, mw, adr, ret, ill} = '0;
        rs = 2'b00; sa = 2'b00; sbs = 2'b00; aop = 2'b00;
        supported = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
                    (o == 7'b0010011) || (o == 7'b1100011);
`ifdef RISCV_CTRL_JAL_EN
        if (o == 7'b1101111) supported = 1'b1;
`endif
        case (st)
            ST_FETCH:    begin irw = 1; sbs = 2'b10; rs = 2'b10; pcu = 1; end
            ST_DECODE:   begin sa = 2'b01; sbs = 2'b01; ill = ~supported; end
            ST_MEMADR:   begin sa = 2'b10; sbs = 2'b01; end
            ST_MEMREAD:  begin adr = 1; end
            ST_MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
            ST_MEMWRITE: begin adr = 1; mw = 1; ret = 1; end
            ST_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            ST_ALUWB:    begin rw = 1; ret = 1; end
            ST_EXECI:    begin sa = 2'b10; sbs = 2'b01; aop = 2'b10; end
            ST_JAL:      begin sa = 2'b01; sbs = 2'b10; pcu = 1; ret = 1; end
            ST_BEQ:      begin sa = 2'b10; aop = 2'b01; br = 1; ret = 1; end
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 2'b01;
            7'b1100011: imm = 2'b10;
`ifdef RISCV_CTRL_JAL_EN
            7'b1101111: imm = 2'b11;
`endif
            default:    imm = 2'b00;
        endcase
        if (aop == 2'b01) ac = 3'b001;
        else if (aop == 2'b10) begin
            case (f3)
                3'b000:  ac = (o[5] && f7) ? 3'b001 : 3'b000;
                3'b010:  ac = 3'b101;
                3'b110:  ac = 3'b011;
                3'b111:  ac = 3'b010;
                default: ac = 3'b000;
            endcase
        end else ac = 3'b000;
        pcw = pcu | (br & z);
        if (rst) {pcw, irw, rw, mw, ret, ill} = '0;
        return {pcw, irw, rw, mw, adr, rs, sa, sbs, imm, ac, ret, ill};
    endfunction

    task automatic step(input string nm, input int st);
        logic [17:0] got, exp;
        sb.push_back(model(st, op, funct3, funct7b5, zero, s_rst));
        @(negedge clk);
        got = {pc_write, ir_write, reg_write, mem_write, adr_src, result_src, alu_src_a,
               alu_src_b, imm_src, alu_control, instr_retired, illegal_instr};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s state=%0d actual=%05h required=%05h", nm, st, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    function automatic vec_t mk(input string n, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input int len,
                                input int s2, input int s3, input int s4);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.len = len;
        v.st[0] = ST_FETCH; v.st[1] = ST_DECODE; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        return v;
    endfunction

    initial begin
        tbl.push_back(mk("lw",        7'b0000011, 3'b010, 1'b0, 1'b1, 5, ST_MEMADR, ST_MEMREAD, ST_MEMWB));
        tbl.push_back(mk("sw",        7'b0100011, 3'b010, 1'b0, 1'b0, 4, ST_MEMADR, ST_MEMWRITE, 0));
        tbl.push_back(mk("r_add",     7'b0110011, 3'b000, 1'b0, 1'b1, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("r_sub",     7'b0110011, 3'b000, 1'b1, 1'b0, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("r_or",      7'b0110011, 3'b110, 1'b0, 1'b0, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("r_and",     7'b0110011, 3'b111, 1'b0, 1'b0, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("r_slt",     7'b0110011, 3'b010, 1'b0, 1'b0, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("r_other",   7'b0110011, 3'b001, 1'b1, 1'b0, 4, ST_EXECR, ST_ALUWB, 0));
        tbl.push_back(mk("addi_f7",   7'b0010011, 3'b000, 1'b1, 1'b0, 4, ST_EXECI, ST_ALUWB, 0));
        tbl.push_back(mk("ori",       7'b0010011, 3'b110, 1'b0, 1'b1, 4, ST_EXECI, ST_ALUWB, 0));
        tbl.push_back(mk("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, ST_BEQ, 0, 0));
        tbl.push_back(mk("beq_not",   7'b1100011, 3'b000, 1'b0, 1'b0, 3, ST_BEQ, 0, 0));
        tbl.push_back(mk("illegal",   7'b1111111, 3'b000, 1'b0, 1'b1, 2, 0, 0, 0));
`ifdef RISCV_CTRL_JAL_EN
        tbl.push_back(mk("jal",       7'b1101111, 3'b000, 1'b0, 1'b0, 3, ST_JAL, 0, 0));
`else
        tbl.push_back(mk("jal_off",   7'b1101111, 3'b000, 1'b0, 1'b0, 2, 0, 0, 0));
`endif
        tbl.push_back(mk("lw_again",  7'b0000011, 3'b010, 1'b0, 1'b0, 5, ST_MEMADR, ST_MEMREAD, ST_MEMWB));

        s_rst = 1'b1;
        set_in(7'b0000000, 3'b000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        step("reset0", ST_FETCH);
        set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
        step("reset1", ST_FETCH);
        s_rst = 1'b0;

        foreach (tbl[i]) begin
            set_in(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z);
            for (int c = 0; c < tbl[i].len; c++) step(tbl[i].name, tbl[i].st[c]);
        end

        // Reset in MEMREAD of lw: instruction abandoned, next cycle is FETCH of a fresh sw
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("rst_mr_f", ST_FETCH);
        step("rst_mr_d", ST_DECODE);
        step("rst_mr_a", ST_MEMADR);
        s_rst = 1'b1;
        step("rst_mr_r", ST_MEMREAD);
        s_rst = 1'b0;
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        step("rst_mr_sw_f", ST_FETCH);
        step("rst_mr_sw_d", ST_DECODE);
        step("rst_mr_sw_a", ST_MEMADR);
        step("rst_mr_sw_w", ST_MEMWRITE);

        // Reset held during MEMWB: the write and retire pulses must be suppressed
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("rst_wb_f", ST_FETCH);
        step("rst_wb_d", ST_DECODE);
        step("rst_wb_a", ST_MEMADR);
        step("rst_wb_r", ST_MEMREAD);
        s_rst = 1'b1;
        step("rst_wb_w", ST_MEMWB);
        s_rst = 1'b0;
        set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
        step("rst_wb_next_f", ST_FETCH);
        step("rst_wb_next_d", ST_DECODE);
        step("rst_wb_next_e", ST_EXECR);
        step("rst_wb_next_w", ST_ALUWB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
